// File: rtl/video_crtc_timing.sv
// video_crtc_timing
//   6545-style CRTC raster timing generator. Reads the decoded R0..R13
//   register values and, once per character clock enable, emits hsync,
//   vsync, display enable, refresh memory address and raster address for
//   the character being produced, then advances the raster counters.
//
// Ports
//   sys_clock_i          system clock
//   reset_i              synchronous active-high reset
//   clk_en_i             character clock enable
//   r0..r9, r1213        live register values (see names for meaning)
//   h_sync_o, v_sync_o   active-high syncs
//   de_o                 display enable
//   ma_o, ra_o           refresh memory address / raster address
//   frame_start_o        one-cycle pulse on the char that starts a frame
//
// State   | meaning
// --------+-------------------------------------------------------------
// ACTIVE  | counting character rows 0..R4, ra runs 0..R9 within a row
// ADJUST  | R5 extra scanlines after the last row, display blanked
//
// A new frame is an action on the ADJUST->ACTIVE (or ACTIVE->ACTIVE when
// R5=0) transition: row/ra cleared and the start address reloaded.
module video_crtc_timing #(
  parameter bit SYNC_WIDTH_ZERO_IS_16 = 1'b1
) (
  input  logic        sys_clock_i,
  input  logic        reset_i,
  input  logic        clk_en_i,
  input  logic [7:0]  r0_h_total_i,
  input  logic [7:0]  r1_h_displayed_i,
  input  logic [7:0]  r2_h_sync_pos_i,
  input  logic [3:0]  r3_h_sync_width_i,
  input  logic [3:0]  r3_v_sync_width_i,
  input  logic [6:0]  r4_v_total_i,
  input  logic [4:0]  r5_v_adjust_i,
  input  logic [6:0]  r6_v_displayed_i,
  input  logic [6:0]  r7_v_sync_pos_i,
  input  logic [4:0]  r9_max_scan_line_i,
  input  logic [13:0] r1213_start_addr_i,
  output logic        h_sync_o,
  output logic        v_sync_o,
  output logic        de_o,
  output logic [13:0] ma_o,
  output logic [4:0]  ra_o,
  output logic        frame_start_o
);

  typedef enum logic {ST_ACTIVE, ST_ADJUST} state_t;

  state_t      state;
  logic [7:0]  h_cnt;
  logic [4:0]  ra;
  logic [6:0]  row;
  logic [4:0]  adj_cnt;
  logic [13:0] ma_row;
  logic [3:0]  hs_left;   // hsync chars still to go after the current one
  logic [3:0]  vs_left;   // vsync scanlines still to go after the current one
  logic        vs_on;

  logic        h_wrap;
  logic        hs_en, hs_trig, hs_now;
  logic        vs_en, vs_trig, vs_now;
  logic [3:0]  vs_cur;
  logic        v_disp;

  // Wrap on >= so that lowering R0 below the current count still ends the line.
  assign h_wrap = (h_cnt >= r0_h_total_i);

  // A programmed width of 0 loads 15 remaining (16 total) via 4-bit wrap.
  assign hs_en   = (r3_h_sync_width_i != 4'd0) || SYNC_WIDTH_ZERO_IS_16;
  assign hs_trig = (hs_left == 4'd0) && (h_cnt == r2_h_sync_pos_i) && hs_en;
  assign hs_now  = (hs_left != 4'd0) || hs_trig;

  assign vs_en   = (r3_v_sync_width_i != 4'd0) || SYNC_WIDTH_ZERO_IS_16;
  assign vs_trig = !vs_on && (state == ST_ACTIVE) && (h_cnt == 8'd0) &&
                   (ra == 5'd0) && (row == r7_v_sync_pos_i) && vs_en;
  assign vs_now  = vs_on || vs_trig;
  assign vs_cur  = vs_trig ? (r3_v_sync_width_i - 4'd1) : vs_left;

  assign v_disp  = (row < r6_v_displayed_i) && (state == ST_ACTIVE);

  always_ff @(posedge sys_clock_i) begin
    if (reset_i) begin
      state         <= ST_ACTIVE;
      h_cnt         <= 8'd0;
      ra            <= 5'd0;
      row           <= 7'd0;
      adj_cnt       <= 5'd0;
      ma_row        <= r1213_start_addr_i;
      hs_left       <= 4'd0;
      vs_left       <= 4'd0;
      vs_on         <= 1'b0;
      h_sync_o      <= 1'b0;
      v_sync_o      <= 1'b0;
      de_o          <= 1'b0;
      ma_o          <= 14'd0;
      ra_o          <= 5'd0;
      frame_start_o <= 1'b0;
    end else begin
      frame_start_o <= 1'b0;
      if (clk_en_i) begin
        // Outputs describe the char at the current counters.
        h_sync_o      <= hs_now;
        v_sync_o      <= vs_now;
        de_o          <= (h_cnt < r1_h_displayed_i) && v_disp;
        ma_o          <= ma_row + {6'd0, h_cnt};
        ra_o          <= ra;
        frame_start_o <= (h_cnt == 8'd0) && (ra == 5'd0) && (row == 7'd0) &&
                         (state == ST_ACTIVE);

        if (hs_trig)
          hs_left <= r3_h_sync_width_i - 4'd1;
        else if (hs_left != 4'd0)
          hs_left <= hs_left - 4'd1;

        // vsync counts scanlines, so it only steps at line end.
        if (vs_now && h_wrap) begin
          if (vs_cur == 4'd0) begin
            vs_on <= 1'b0;
          end else begin
            vs_on   <= 1'b1;
            vs_left <= vs_cur - 4'd1;
          end
        end else if (vs_now) begin
          vs_on   <= 1'b1;
          vs_left <= vs_cur;
        end

        if (h_wrap) begin
          h_cnt <= 8'd0;
          case (state)
            ST_ACTIVE: begin
              if (ra >= r9_max_scan_line_i) begin
                ra <= 5'd0;
                if (row >= r4_v_total_i) begin
                  if (r5_v_adjust_i != 5'd0) begin
                    state   <= ST_ADJUST;
                    adj_cnt <= r5_v_adjust_i - 5'd1;
                    ma_row  <= ma_row + {6'd0, r1_h_displayed_i};
                  end else begin
                    row    <= 7'd0;
                    ma_row <= r1213_start_addr_i;
                  end
                end else begin
                  row    <= row + 7'd1;
                  ma_row <= ma_row + {6'd0, r1_h_displayed_i};
                end
              end else begin
                ra <= ra + 5'd1;
              end
            end
            ST_ADJUST: begin
              if (adj_cnt == 5'd0) begin
                state  <= ST_ACTIVE;
                ra     <= 5'd0;
                row    <= 7'd0;
                ma_row <= r1213_start_addr_i;
              end else begin
                adj_cnt <= adj_cnt - 5'd1;
                ra      <= ra + 5'd1;
              end
            end
          endcase
        end else begin
          h_cnt <= h_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_video_crtc_timing.sv
module tb_video_crtc_timing;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        clk_en;
  logic [7:0]  r0, r1, r2;
  logic [3:0]  r3h, r3v;
  logic [6:0]  r4, r6, r7;
  logic [4:0]  r5, r9;
  logic [13:0] start;
  logic        h_sync, v_sync, de, frame_start;
  logic [13:0] ma;
  logic [4:0]  ra;

  always #5 clk_sys = ~clk_sys;

  video_crtc_timing #(.SYNC_WIDTH_ZERO_IS_16(1'b1)) dut (
    .sys_clock_i        (clk_sys),
    .reset_i            (reset),
    .clk_en_i           (clk_en),
    .r0_h_total_i       (r0),
    .r1_h_displayed_i   (r1),
    .r2_h_sync_pos_i    (r2),
    .r3_h_sync_width_i  (r3h),
    .r3_v_sync_width_i  (r3v),
    .r4_v_total_i       (r4),
    .r5_v_adjust_i      (r5),
    .r6_v_displayed_i   (r6),
    .r7_v_sync_pos_i    (r7),
    .r9_max_scan_line_i (r9),
    .r1213_start_addr_i (start),
    .h_sync_o           (h_sync),
    .v_sync_o           (v_sync),
    .de_o               (de),
    .ma_o               (ma),
    .ra_o               (ra),
    .frame_start_o      (frame_start)
  );

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [13:0] ma;
    logic [4:0]  ra;
    logic        fs;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  obs_t  last_exp;
  int    n_checks = 0;
  int    n_fail   = 0;
  int    k;

  // Analytic frame model for the bench register set (R1=6, R2=7, R4=4,
  // R5=1, R6=3, R7=3, R9=1, vsync width 2): 11 scanlines per frame, rows
  // of two scanlines, one adjust line whose MA base is start+5*R1.
  function automatic obs_t model(int kk, int r0v, int hw, logic [13:0] st);
    obs_t e;
    int ll, p, line, h, mrow;
    ll   = r0v + 1;
    p    = kk % (11 * ll);
    line = p / ll;
    h    = p % ll;
    mrow = (line < 10) ? (line / 2) * 6 : 30;
    e.hs = (h >= 7) && (h < 7 + hw);
    e.vs = (line == 6) || (line == 7);
    e.de = (h < 6) && (line < 6);
    e.ma = st + 14'(mrow + h);
    e.ra = (line < 10) ? 5'(line % 2) : 5'd0;
    e.fs = (p == 0);
    return e;
  endfunction

  task automatic push_exp(input obs_t e, input string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check_out();
    obs_t got, e;
    string tag;
    got.hs = h_sync; got.vs = v_sync; got.de = de;
    got.ma = ma;     got.ra = ra;     got.fs = frame_start;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: got %h expected none", got);
    end else begin
      e   = exp_q.pop_front();
      tag = tag_q.pop_front();
      assert (got === e) else begin
        n_fail++;
        $error("FAIL %s: got hs%b vs%b de%b ma%h ra%0d fs%b, expected hs%b vs%b de%b ma%h ra%0d fs%b",
               tag, got.hs, got.vs, got.de, got.ma, got.ra, got.fs,
               e.hs, e.vs, e.de, e.ma, e.ra, e.fs);
      end
    end
  endtask

  task automatic cycle(input logic en, input logic rst);
    clk_en = en;
    reset  = rst;
    @(posedge clk_sys);
    #1;
    check_out();
  endtask

  task automatic do_reset(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      push_exp('0, tag);
      cycle(1'b1, 1'b1);
    end
    reset    = 1'b0;
    k        = 0;
    last_exp = '0;
  endtask

  // Each char is predicted, driven and then compared; every 7th char is
  // followed by an idle cycle where outputs must hold and frame_start drop.
  task automatic run_model(input int n, input int r0v, input int hw,
                           input logic [13:0] st, input string tag);
    obs_t e;
    for (int i = 0; i < n; i++) begin
      e = model(k, r0v, hw, st);
      push_exp(e, tag);
      cycle(1'b1, 1'b0);
      k++;
      last_exp = e;
      if (i % 7 == 3) begin
        e    = last_exp;
        e.fs = 1'b0;
        push_exp(e, {tag, "_hold"});
        cycle(1'b0, 1'b0);
      end
    end
  endtask

  initial begin
    obs_t e;
    reset = 1'b1; clk_en = 1'b0;
    r0 = 8'd9; r1 = 8'd6; r2 = 8'd7; r3h = 4'h2; r3v = 4'h2;
    r4 = 7'd4; r5 = 5'd1; r6 = 7'd3; r7 = 7'd3; r9 = 5'd1;
    start = 14'h0100;

    do_reset(2, "reset");
    run_model(220, 9, 2, 14'h0100, "frame");
    run_model(45, 9, 2, 14'h0100, "midframe");  // now inside row 2

    start = 14'h3FFE;
    do_reset(1, "reset_mid");
    run_model(30, 9, 2, 14'h3FFE, "ma_wrap");

    start = 14'h0100;
    r0 = 8'd0;
    do_reset(1, "reset_r0");
    run_model(25, 0, 2, 14'h0100, "r0_zero");

    r0 = 8'd24; r3h = 4'h0;
    do_reset(1, "reset_hs16");
    run_model(60, 24, 16, 14'h0100, "hsync16");

    // Live R0 change: after chars 0..6 the counter sits at 7; R0 drops to
    // 4, so char 7 ends the line and following lines are 5 chars long.
    r0 = 8'd9; r3h = 4'h2;
    do_reset(1, "reset_live");
    run_model(7, 9, 2, 14'h0100, "pre_live");
    r0 = 8'd4;
    e = '{hs: 1'b1, vs: 1'b0, de: 1'b0, ma: 14'h0107, ra: 5'd0, fs: 1'b0};
    push_exp(e, "live_wrap");
    cycle(1'b1, 1'b0);
    for (int h = 0; h < 5; h++) begin
      e = '{hs: (h == 0), vs: 1'b0, de: 1'b1, ma: 14'h0100 + 14'(h), ra: 5'd1, fs: 1'b0};
      push_exp(e, "live_line1");
      cycle(1'b1, 1'b0);
    end
    e = '{hs: 1'b0, vs: 1'b0, de: 1'b1, ma: 14'h0106, ra: 5'd0, fs: 1'b0};
    push_exp(e, "live_line2");
    cycle(1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
